// File: rtl/mmio_input_ctrl.sv
// Memory-mapped input controller: per-channel sync + debounce, DATA/CTRL registers, registered irq.
// Define MMIO_INPUT_EDGE_CAPTURE_EN to add the sticky rising-edge register at BASEADDR+8.
module mmio_input_ctrl #(
  parameter int               DBITS      = 32,
  parameter int               NCH        = 4,
  parameter logic [DBITS-1:0] BASEADDR   = 32'hFFFFF080,
  parameter int               DEBOUNCE   = 16,
  parameter bit               ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [NCH-1:0]   raw_in,
  input  logic [DBITS-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata,
  output logic             sel,
  output logic             irq
);

  localparam int               CW        = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [DBITS-1:0] CTRL_ADDR = BASEADDR + DBITS'(4);

  logic [NCH-1:0] raw_c, sync1, s, db, db_upd;
  logic [CW-1:0]  cnt [NCH];
  logic           ready, overrun, ie;
  logic           hit_data, hit_ctrl, chg, rd_data, wr_ctrl, ready_clr, irq_src;
  logic           unused_wdata;

  assign raw_c = ACTIVE_LOW ? ~raw_in : raw_in;

  always_comb begin
    db_upd = '0;
    for (int i = 0; i < NCH; i++) begin
      db_upd[i] = (s[i] != db[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      sync1 <= '0;
      s     <= '0;
      db    <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw_c;
      s     <= sync1;
      // db_upd only fires where s differs from db, so flipping those bits takes s
      db    <= db ^ db_upd;
      for (int i = 0; i < NCH; i++) begin
        if (s[i] == db[i] || db_upd[i]) cnt[i] <= '0;
        else                             cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  assign hit_data  = (addr == BASEADDR);
  assign hit_ctrl  = (addr == CTRL_ADDR);
  assign chg       = |db_upd;
  assign rd_data   = rd_en & hit_data;
  assign wr_ctrl   = wr_en & hit_ctrl;
  assign ready_clr = rd_data | (wr_ctrl & ~wdata[0]);
  assign unused_wdata = ^wdata;

`ifdef MMIO_INPUT_EDGE_CAPTURE_EN
  localparam logic [DBITS-1:0] EDGE_ADDR = BASEADDR + DBITS'(8);
  logic           hit_edge;
  logic [NCH-1:0] edge_q, edge_clr;

  assign hit_edge = (addr == EDGE_ADDR);
  assign edge_clr = (wr_en & hit_edge) ? wdata[NCH-1:0] : '0;
  assign sel      = hit_data | hit_ctrl | hit_edge;
  assign irq_src  = ready | (|edge_q);

  always_ff @(posedge clk) begin
    if (!RESET_N) edge_q <= '0;
    else          edge_q <= (edge_q & ~edge_clr) | (db_upd & s);
  end
`else
  assign sel     = hit_data | hit_ctrl;
  assign irq_src = ready;
`endif

  always_comb begin
    rdata = '0;
    if (hit_data) begin
      rdata[NCH-1:0] = db;
    end else if (hit_ctrl) begin
      rdata[0] = ready;
      rdata[2] = overrun;
      rdata[8] = ie;
    end
`ifdef MMIO_INPUT_EDGE_CAPTURE_EN
    else if (hit_edge) begin
      rdata[NCH-1:0] = edge_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (chg)            ready <= 1'b1;
      else if (ready_clr) ready <= 1'b0;
      // a change racing a clear leaves OVERRUN alone; otherwise an unread change overruns
      if (chg && ready_clr)  overrun <= overrun;
      else if (chg && ready) overrun <= 1'b1;
      else if (wr_ctrl)      overrun <= overrun & wdata[2];
      if (wr_ctrl) ie <= wdata[8];
      irq <= ie & irq_src;
    end
  end

endmodule

// File: tb/tb_mmio_input_ctrl.sv
// Directed bench for mmio_input_ctrl: reset, debounce latency/glitch, decode table, READY/OVERRUN/IE, reset mid-debounce, edge capture.
module tb_mmio_input_ctrl;
  localparam logic [31:0] BASE = 32'hFFFFF080;
  localparam logic [31:0] CTRL = BASE + 32'd4;
  localparam logic [31:0] EDGA = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic [3:0]  raw_in;
  logic [31:0] addr, wdata;
  logic        rd_en, wr_en;
  logic [31:0] rdata;
  logic        sel, irq;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  mmio_input_ctrl dut (
    .clk(clk), .RESET_N(RESET_N), .raw_in(raw_in), .addr(addr), .rd_en(rd_en),
    .wr_en(wr_en), .wdata(wdata), .rdata(rdata), .sel(sel), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic peek(input logic [31:0] a, input string name, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
    wdata = '0;
  endtask

  task automatic load();
    addr  = BASE;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    logic bad;
    tbl[0] = '{BASE, 1'b1, 32'h2};
    tbl[1] = '{CTRL, 1'b1, 32'h1};
`ifdef MMIO_INPUT_EDGE_CAPTURE_EN
    tbl[2] = '{EDGA, 1'b1, 32'h2};
`else
    tbl[2] = '{EDGA, 1'b0, 32'h0};
`endif
    tbl[3] = '{BASE - 32'd4, 1'b0, 32'h0};
    tbl[4] = '{BASE + 32'd12, 1'b0, 32'h0};
    tbl[5] = '{BASE + 32'd1, 1'b0, 32'h0};
    tbl[6] = '{BASE ^ 32'h8000_0000, 1'b0, 32'h0};

    RESET_N = 1'b0; raw_in = 4'hF; addr = BASE; wdata = '0; rd_en = 1'b0; wr_en = 1'b0;

    // reset and idle
    tick(2);
    RESET_N = 1'b1;
    peek(BASE, "rst_data", 32'h0);
    peek(CTRL, "rst_ctrl", 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
`ifdef MMIO_INPUT_EDGE_CAPTURE_EN
    peek(EDGA, "rst_edge", 32'h0);
`endif
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      addr = BASE; #1; if (rdata != 0) bad = 1'b1;
      addr = CTRL; #1; if (rdata != 0) bad = 1'b1;
      if (irq !== 1'b0) bad = 1'b1;
    end
    chk("idle_quiet", {31'b0, bad}, 32'h0);

    // glitch shorter than DEBOUNCE, then a held press
    raw_in[1] = 1'b0;
    tick(10);
    raw_in[1] = 1'b1;
    tick(30);
    peek(BASE, "glitch_data", 32'h0);
    peek(CTRL, "glitch_ctrl", 32'h0);
    raw_in[1] = 1'b0;
    tick(17);
    peek(BASE, "press_17", 32'h0);
    tick(1);
    peek(BASE, "press_18", 32'h2);
    peek(CTRL, "press_ctrl", 32'h1);
    chk("press_irq", {31'b0, irq}, 32'h0);

    // address decode table
    for (int i = 0; i < 7; i++) begin
      addr = tbl[i].addr;
      #1;
      chk($sformatf("tbl%0d_sel", i), {31'b0, sel}, {31'b0, tbl[i].exp_sel});
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      tick(1);
    end

    // read-clear, overrun, ignored writes
    addr = BASE; rd_en = 1'b1; #1;
    chk("load_rdata", rdata, 32'h2);
    tick(1);
    rd_en = 1'b0;
    peek(CTRL, "load_clr", 32'h0);
    raw_in[1] = 1'b1;
    tick(20);
    peek(CTRL, "release_ctrl", 32'h1);
    raw_in[1] = 1'b0;
    tick(20);
    peek(CTRL, "overrun_ctrl", 32'h5);
    wr(BASE, 32'h0);
    wr(BASE - 32'd4, 32'h0);
`ifndef MMIO_INPUT_EDGE_CAPTURE_EN
    wr(EDGA, 32'h0);
`endif
    peek(BASE, "wr_data_ign", 32'h2);
    peek(CTRL, "wr_unimpl_ign", 32'h5);
    wr(CTRL, 32'h0);
    peek(CTRL, "ctrl_clr", 32'h0);

    // interrupt timing and change racing a DATA read
`ifdef MMIO_INPUT_EDGE_CAPTURE_EN
    wr(EDGA, 32'hF);
`endif
    wr(CTRL, 32'h100);
    peek(CTRL, "ie_set", 32'h100);
    tick(1);
    chk("ie_irq_idle", {31'b0, irq}, 32'h0);
    raw_in[0] = 1'b0;
    tick(18);
    peek(CTRL, "irq_ready", 32'h101);
    chk("irq_lag0", {31'b0, irq}, 32'h0);
    tick(1);
    chk("irq_lag1", {31'b0, irq}, 32'h1);
    raw_in[2] = 1'b0;
    tick(17);
    addr = BASE; rd_en = 1'b1; #1;
    chk("race_rdata", rdata, 32'h3);
    tick(1);
    rd_en = 1'b0;
    peek(CTRL, "race_ctrl", 32'h101);
    peek(BASE, "race_data", 32'h7);
    chk("race_irq", {31'b0, irq}, 32'h1);

    // reset with ch0 mid-debounce
    raw_in = 4'hF;
    tick(20);
    peek(CTRL, "rel_overrun", 32'h105);
    wr(CTRL, 32'h0);
    tick(1);
    raw_in[0] = 1'b0;
    tick(10);
    RESET_N = 1'b0;
    tick(1);
    RESET_N = 1'b1;
    peek(BASE, "mid_rst_data", 32'h0);
    peek(CTRL, "mid_rst_ctrl", 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    tick(17);
    peek(BASE, "requal_17", 32'h0);
    tick(1);
    peek(BASE, "requal_18", 32'h1);
    peek(CTRL, "requal_ctrl", 32'h1);

`ifdef MMIO_INPUT_EDGE_CAPTURE_EN
    // sticky rising edges, write-1-to-clear
    raw_in = 4'hF;
    tick(20);
    wr(CTRL, 32'h100);
    wr(EDGA, 32'hF);
    tick(2);
    chk("edge_pre_irq", {31'b0, irq}, 32'h0);
    raw_in = 4'b0110;
    tick(18);
    peek(EDGA, "edge_09", 32'h9);
    tick(1);
    chk("edge_irq", {31'b0, irq}, 32'h1);
    wr(EDGA, 32'h1);
    peek(EDGA, "edge_08", 32'h8);
    chk("edge_irq_hold", {31'b0, irq}, 32'h1);
    wr(EDGA, 32'h8);
    peek(EDGA, "edge_00", 32'h0);
    load();
    tick(1);
    peek(CTRL, "edge_ctrl_end", 32'h100);
    chk("edge_irq_off", {31'b0, irq}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
